// File: rtl/cmd_if_pkg.sv
// Shared types and constants for the host command/response path.
// Used by the UART wrapper, the command-config block and the bench.
package cmd_if_pkg;

    localparam int CMD_BYTES = 3;
    localparam int CMD_W     = 8 * CMD_BYTES;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        HOLD
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    localparam logic [7:0] DUMP_CH      = 8'h01;
    localparam logic [7:0] CFG_GAIN     = 8'h02;
    localparam logic [7:0] CFG_TRG_LVL  = 8'h03;
    localparam logic [7:0] WRT_TRG_POS  = 8'h04;
    localparam logic [7:0] SET_DEC      = 8'h05;
    localparam logic [7:0] CFG_TRG_TYPE = 8'h06;
    localparam logic [7:0] WRT_EEP      = 8'h08;
    localparam logic [7:0] EEP_RD       = 8'h09;

    function automatic logic [7:0] cmd_opcode(input logic [CMD_W-1:0] c);
        return c[CMD_W-1 -: 8];
    endfunction

endpackage

// File: rtl/cmd_uart_wrapper_if.sv
// Bundle of UART rx/tx, command and response handshake signals.
// slave = the wrapper, master = the UART cores and command consumer.
interface cmd_uart_wrapper_if;

    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        frame_err;

    modport master (
        output rx_rdy,
        output rx_data,
        output clr_cmd_rdy,
        output resp_data,
        output send_resp,
        output tx_done,
        input  clr_rx_rdy,
        input  cmd,
        input  cmd_rdy,
        input  resp_sent,
        input  trmt,
        input  tx_data,
        input  frame_err
    );

    modport slave (
        input  rx_rdy,
        input  rx_data,
        input  clr_cmd_rdy,
        input  resp_data,
        input  send_resp,
        input  tx_done,
        output clr_rx_rdy,
        output cmd,
        output cmd_rdy,
        output resp_sent,
        output trmt,
        output tx_data,
        output frame_err
    );

endinterface

// File: rtl/cmd_uart_wrapper_resp_tx_ctrl.sv
// Response transmit control: latches one byte, pulses trmt,
// and reports completion with a single-cycle resp_sent.
module resp_tx_ctrl
    import cmd_if_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] resp_data,
    input  logic       send_resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent
);

    tx_state_t state;

    // Tx FSM with registered single-cycle trmt/resp_sent pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TX_IDLE;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
            resp_sent <= 1'b0;
        end else begin
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_data <= resp_data;
                        trmt    <= 1'b1;
                        state   <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        resp_sent <= 1'b1;
                        state     <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Host end of the command link: assembles 3 rx bytes into a command,
// drops stale partial frames, and forwards response bytes to the tx.
module cmd_uart_wrapper
    import cmd_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    cmd_uart_wrapper_if.slave   bus
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    rx_state_t       state;
    logic [15:0]     hi_bytes;
    logic [TO_W-1:0] to_cnt;
    logic [23:0]     cmd_q;
    logic            cmd_rdy_q;
    logic            frame_err_q;
    logic            take;
    logic            mid_frame;
    logic            expire;

    // A byte is taken whenever one is offered and no command is held
    assign take      = bus.rx_rdy && (state != HOLD);
    assign mid_frame = (state == WAIT_B1) || (state == WAIT_B2);
    assign expire    = TO_EN && mid_frame && !take &&
                       (to_cnt == TO_LAST);

    assign bus.clr_rx_rdy = take;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.frame_err  = frame_err_q;

    // Inter-byte idle counter; only runs while a frame is partial
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (take || expire) begin
            to_cnt <= '0;
        end else if (TO_EN && mid_frame) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Rx FSM: byte slotting, command hand-off and timeout abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_B0;
            hi_bytes    <= 16'h0000;
            cmd_q       <= 24'h000000;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state)
                WAIT_B0: begin
                    if (take) begin
                        hi_bytes[15:8] <= bus.rx_data;
                        state          <= WAIT_B1;
                    end
                end
                WAIT_B1: begin
                    if (take) begin
                        hi_bytes[7:0] <= bus.rx_data;
                        state         <= WAIT_B2;
                    end else if (expire) begin
                        frame_err_q <= 1'b1;
                        state       <= WAIT_B0;
                    end
                end
                WAIT_B2: begin
                    if (take) begin
                        cmd_q     <= {hi_bytes, bus.rx_data};
                        cmd_rdy_q <= 1'b1;
                        state     <= HOLD;
                    end else if (expire) begin
                        frame_err_q <= 1'b1;
                        state       <= WAIT_B0;
                    end
                end
                HOLD: begin
                    if (bus.clr_cmd_rdy) begin
                        cmd_rdy_q <= 1'b0;
                        state     <= WAIT_B0;
                    end
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

    resp_tx_ctrl u_tx (
        .clk       (clk),
        .rst       (rst),
        .resp_data (bus.resp_data),
        .send_resp (bus.send_resp),
        .tx_done   (bus.tx_done),
        .trmt      (bus.trmt),
        .tx_data   (bus.tx_data),
        .resp_sent (bus.resp_sent)
    );

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed bench for cmd_uart_wrapper: frame assembly, hold/backpressure,
// timeout abort and expiry race, response tx, and mid-flight reset.
module tb_cmd_uart_wrapper;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    cmd_uart_wrapper_if bus ();
    cmd_uart_wrapper_if bus4 ();

    cmd_uart_wrapper #(
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cmd_uart_wrapper #(
        .TIMEOUT_CYCLES (4),
        .TO_W           (3)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        #1;
        chk("clr_rx_rdy", 32'(bus.clr_rx_rdy), 1);
        tick();
        bus.rx_rdy = 1'b0;
    endtask

    // Called right after a consumed byte; returns edges until frame_err
    task automatic wait_err(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.frame_err) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.rx_rdy = 0; bus.rx_data = 0; bus.clr_cmd_rdy = 0;
        bus.resp_data = 0; bus.send_resp = 0; bus.tx_done = 0;
        bus4.rx_rdy = 0; bus4.rx_data = 0; bus4.clr_cmd_rdy = 0;
        bus4.resp_data = 0; bus4.send_resp = 0; bus4.tx_done = 0;
        tick();
        tick();
        chk("rst_cmd", 32'(bus.cmd), 32'h0);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 0);
        chk("rst_trmt", 32'(bus.trmt), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst_resp_sent", 32'(bus.resp_sent), 0);
        chk("rst_frame_err", 32'(bus.frame_err), 0);
        chk("rst_clr_rx", 32'(bus.clr_rx_rdy), 0);
        rst = 1'b0;
        tick();

        // three bytes, three cycles apart
        put_byte(8'h08); tick(); tick();
        put_byte(8'h05); tick(); tick();
        chk("pre_cmd_rdy", 32'(bus.cmd_rdy), 0);
        put_byte(8'hA7);
        chk("cmd1_rdy", 32'(bus.cmd_rdy), 1);
        chk("cmd1", 32'(bus.cmd), 32'h0805A7);

        // held command blocks further bytes
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h09;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hold_clr_rx", 32'(bus.clr_rx_rdy), 0);
            tick();
        end
        chk("hold_cmd_rdy", 32'(bus.cmd_rdy), 1);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("rel_same_cyc", 32'(bus.clr_rx_rdy), 0);
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("rel_cmd_rdy", 32'(bus.cmd_rdy), 0);
        chk("rel_cmd_kept", 32'(bus.cmd), 32'h0805A7);
        #1;
        chk("after_rel_clr", 32'(bus.clr_rx_rdy), 1);
        tick();
        bus.rx_rdy = 1'b0;

        // partial frame {09} times out: byte edge + 16 edges
        wait_err(k);
        chk("to_lat_09", k, 16);
        tick();
        chk("to_pulse_end", 32'(bus.frame_err), 0);

        // single byte then silence
        put_byte(8'h01);
        wait_err(k);
        chk("to_lat_01", k, 16);
        tick();
        put_byte(8'h01);
        put_byte(8'h02);
        put_byte(8'h03);
        chk("cmd2", 32'(bus.cmd), 32'h010203);
        chk("cmd2_rdy", 32'(bus.cmd_rdy), 1);
        k = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.frame_err) k++;
        end
        chk("no_to_in_hold", k, 0);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;

        // response path
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("idle_tx_done", 32'(bus.resp_sent), 0);
        bus.resp_data = 8'hA5;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        chk("trmt_pulse", 32'(bus.trmt), 1);
        chk("tx_data", 32'(bus.tx_data), 32'hA5);
        bus.resp_data = 8'hEE;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        chk("trmt_single", 32'(bus.trmt), 0);
        chk("busy_tx_data", 32'(bus.tx_data), 32'hA5);
        tick();
        chk("busy_no_trmt", 32'(bus.trmt), 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("resp_sent", 32'(bus.resp_sent), 1);
        tick();
        chk("resp_sent_end", 32'(bus.resp_sent), 0);

        // reset with a partial frame and a busy transmitter
        put_byte(8'hAA);
        put_byte(8'hBB);
        bus.resp_data = 8'h5A;
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        chk("pre_rst_trmt", 32'(bus.trmt), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_cmd", 32'(bus.cmd), 32'h0);
        chk("mrst_cmd_rdy", 32'(bus.cmd_rdy), 0);
        chk("mrst_trmt", 32'(bus.trmt), 0);
        chk("mrst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("mrst_frame_err", 32'(bus.frame_err), 0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("mrst_tx_idle", 32'(bus.resp_sent), 0);
        put_byte(8'h06);
        chk("mrst_partial", 32'(bus.cmd_rdy), 0);
        put_byte(8'h20);
        put_byte(8'h00);
        chk("cmd3", 32'(bus.cmd), 32'h062000);
        chk("cmd3_rdy", 32'(bus.cmd_rdy), 1);

        // TIMEOUT_CYCLES=4: bytes land exactly in the expiry cycle
        k = 0;
        bus4.rx_rdy  = 1'b1;
        bus4.rx_data = 8'h11;
        tick();
        bus4.rx_rdy = 1'b0;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                if (bus4.frame_err) k++;
            end
            bus4.rx_rdy  = 1'b1;
            bus4.rx_data = (j == 0) ? 8'h22 : 8'h33;
            #1;
            chk("exp_clr_rx", 32'(bus4.clr_rx_rdy), 1);
            tick();
            bus4.rx_rdy = 1'b0;
            if (bus4.frame_err) k++;
        end
        chk("exp_no_err", k, 0);
        chk("exp_cmd", 32'(bus4.cmd), 32'h112233);
        chk("exp_cmd_rdy", 32'(bus4.cmd_rdy), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_uart_wrapper.md
Name: cmd_uart_wrapper

Overview:
- Host-facing end of the command/response interface used by the command-config block.
- Assembles 3 UART receive bytes (MSB first) into a 24-bit command and presents it with a cmd_rdy/clr_cmd_rdy handshake.
- Forwards single-byte responses (send_resp/resp_sent) to the UART transmitter.
- Sits between the UART rx/tx cores and the command-config block.

Parameters:
- TIMEOUT_CYCLES, 1000000, max idle clk cycles between bytes of one command before the partial frame is discarded; 0 disables the timeout.
- TO_W, 20, width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_rdy  in  1  UART rx has a byte in rx_data
- rx_data  in  8  received byte
- clr_rx_rdy  out  1  combinational; high in the cycle a byte is consumed
- cmd  out  24  assembled command {byte0,byte1,byte2}
- cmd_rdy  out  1  cmd valid; held until clr_cmd_rdy
- clr_cmd_rdy  in  1  consumer releases cmd
- resp_data  in  8  response byte
- send_resp  in  1  one-cycle request to transmit resp_data
- resp_sent  out  1  one-cycle pulse when the UART tx finishes the response byte
- trmt  out  1  one-cycle start pulse to UART tx
- tx_data  out  8  byte to transmit; held stable while busy
- tx_done  in  1  UART tx finished
- frame_err  out  1  one-cycle pulse when a partial command times out

Behaviour:
- Reset (rst high at clk edge): all outputs 0, cmd=24'h0, both FSMs idle, timeout counter 0. Reset mid-frame or mid-transmit discards all in-flight state immediately.
- Rx FSM states: WAIT_B0, WAIT_B1, WAIT_B2, HOLD.
- Byte consumption: a byte is consumed when rx_rdy && state != HOLD. clr_rx_rdy=1 in that same cycle. rx_data loads into byte slot 23:16, 15:8 or 7:0 according to state.
- Transitions: WAIT_B0→WAIT_B1→WAIT_B2 on each consumed byte. WAIT_B2 + byte → HOLD.
- Latency: third byte consumed in cycle N → cmd_rdy=1 and cmd valid from cycle N+1.
- HOLD: cmd and cmd_rdy stable. No bytes consumed; backpressure is left to the UART rx (clr_rx_rdy=0).
  - clr_cmd_rdy → cmd_rdy=0 next cycle, state WAIT_B0, cmd retains its value.
  - clr_cmd_rdy and rx_rdy in the same cycle: only the release happens; the byte is consumed the following cycle.
  - clr_cmd_rdy outside HOLD: ignored.
- Timeout: the counter clears on every consumed byte and counts only in WAIT_B1/WAIT_B2.
  - When the count reaches TIMEOUT_CYCLES-1 with no byte: next cycle state=WAIT_B0, counter=0, frame_err pulses for 1 cycle.
  - A byte arriving in the same cycle as expiry wins: it is consumed and there is no error.
  - Never active in WAIT_B0 or HOLD.
- Tx FSM states: TX_IDLE, TX_BUSY.
  - TX_IDLE + send_resp → latch resp_data into tx_data, trmt=1 next cycle (single cycle), go TX_BUSY.
  - TX_BUSY + tx_done → resp_sent=1 next cycle (single cycle), go TX_IDLE.
  - send_resp while TX_BUSY: ignored; tx_data unchanged.
  - tx_done while TX_IDLE: ignored.
- Rx and Tx FSMs are fully independent; the rx path may assemble the next command while a response transmits.

Decomposition:
- Shared package cmd_if_pkg: rx_state_t, tx_state_t enums; CMD_BYTES=3; the command opcode localparams (DUMP_CH..EEP_RD) moved here so the command-config block and the bench share them.
- One sub-module, resp_tx_ctrl: Tx FSM, tx_data latch, trmt/resp_sent pulses. The top level holds the Rx FSM, shift assembly and timeout counter.

Test Plan:
- Bytes 8'h08, 8'h05, 8'hA7 on rx_rdy, 3 cycles apart → 3 clr_rx_rdy pulses; cmd=24'h0805A7 and cmd_rdy=1 one cycle after the 3rd byte.
- cmd_rdy held, 8'h09 offered for 10 cycles → clr_rx_rdy stays 0. clr_cmd_rdy pulse → cmd_rdy=0 next cycle, 8'h09 consumed the cycle after.
- TIMEOUT_CYCLES=16: send 8'h01, then silence → frame_err pulse ~16 cycles later. Then send 01,02,03 → cmd=24'h010203, no error.
- send_resp with resp_data=8'hA5 → trmt 1 cycle with tx_data=8'hA5. A second send_resp (8'hEE) while busy leaves tx_data=8'hA5. tx_done → resp_sent 1 cycle.
- Assert rst after 2 bytes and during TX_BUSY → next cycle all outputs 0. New 3-byte frame 06,20,00 → cmd=24'h062000.
- Byte arrival in the exact expiry cycle with TIMEOUT_CYCLES=4 → no frame_err; frame completes correctly.
